spcm_line_cache: RTL and testbench
==================================

SPCM_LINE_CACHE -- requirements
Module: spcm_line_cache

Interface
REQ-001 Parameter ADDR_BITS, default 24, byte-address width of the serial PCM device.
REQ-002 Parameter LINE_WORDS, default 8, 32-bit words per cache line; power of two, 2..32.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 bus_cs  input  1  read request, level; held high by master until bus_ack.
REQ-006 bus_addr  input  ADDR_BITS  byte address; bits [1:0] ignored.
REQ-007 bus_dout  output  32  read data, valid while bus_ack=1.
REQ-008 bus_ack  output  1  one-cycle completion pulse.
REQ-009 flush  input  1  one-cycle pulse; invalidates the line.
REQ-010 core_cs  output  1  one-cycle start pulse to spcm_core.
REQ-011 core_addr  output  ADDR_BITS  line-aligned start byte address to spcm_core.
REQ-012 core_burst  output  1  burst continue to spcm_core.
REQ-013 core_dout  input  32  word from spcm_core, valid with core_ack.
REQ-014 core_busy  input  1  spcm_core busy.
REQ-015 core_ack  input  1  one-cycle word-valid pulse from spcm_core.

Function
REQ-016 Single line: data array of LINE_WORDS x 32, tag = bus_addr[ADDR_BITS-1:log2(LINE_WORDS)+2], one valid bit.
REQ-017 States IDLE, WAIT, FILL, RESP; reset state IDLE.
REQ-018 IDLE, bus_cs=1, valid=1, tag match (hit): next cycle bus_ack=1 with selected word on bus_dout; latency 1; state stays IDLE.
REQ-019 Bus request is edge-qualified: after bus_ack a still-high bus_cs is not served again until it has been low at least one cycle.
REQ-020 IDLE, bus_cs=1, miss: valid<=0, capture tag; if core_busy=0 go FILL and pulse core_cs with core_burst=1, core_addr=line base; if core_busy=1 go WAIT.
REQ-021 WAIT: stay until core_busy=0, then issue core_cs pulse as in REQ-020 and go FILL.
REQ-022 FILL: each core_ack writes core_dout to word index = fill counter, counter +1 (wraps mod LINE_WORDS).
REQ-023 core_burst stays 1 from core_cs until the cycle of ack number LINE_WORDS-1, then drops to 0 so the core stops after the final word.
REQ-024 On ack number LINE_WORDS: valid<=1, go RESP; RESP asserts bus_ack for one cycle with requested word, then IDLE.
REQ-025 Fill always starts at word 0 of the line; no critical-word-first.
REQ-026 core_ack outside FILL is ignored.
REQ-027 flush in IDLE/RESP: valid<=0 next cycle; flush coincident with a hit lookup wins (treated as miss).
REQ-028 flush during WAIT/FILL: fill completes and request is answered, but valid ends 0.
REQ-029 bus_dout=0 whenever bus_ack=0.

Reset
REQ-030 rst: state IDLE, valid=0, fill counter 0, bus_ack=0, bus_dout=0, core_cs=0, core_burst=0, core_addr=0; data array not cleared.
REQ-031 rst mid-FILL abandons the fill; pending bus request is dropped without ack; spcm_core shares rst.

Configuration
REQ-032 Macro SPCM_CACHE_STAT_EN: when defined, adds outputs hit_cnt and miss_cnt (32 bits each, reset 0, +1 per served hit / per started fill, saturate at 0xFFFFFFFF).
REQ-033 Without SPCM_CACHE_STAT_EN the ports and counters are absent; all other behaviour identical.

Verification
REQ-034 After reset, read 0x000104 -> core_cs pulse, core_addr=0x000100, core_burst=1; 8 acks of 0xA0..0xA7 -> core_burst drops on 7th ack, bus_ack with bus_dout=0xA1 one cycle after 8th ack.
REQ-035 Then read 0x00011C -> bus_ack next cycle, bus_dout=0xA7, no core_cs.
REQ-036 Read 0x000120 (next line) with core_busy=1 for 5 cycles -> no core_cs until busy low, then fill at 0x000120; read 0x000100 afterwards -> miss.
REQ-037 flush asserted during FILL -> request still acked with correct word; immediate re-read of same address -> miss, new core_cs.
REQ-038 rst asserted after 3 acks of a fill -> outputs zero next cycle, no bus_ack; stray core_ack ignored; next read of same address -> full fill.
REQ-039 With SPCM_CACHE_STAT_EN: sequence miss, hit, hit, flush, miss -> hit_cnt=2, miss_cnt=2.

Source files
------------

// File: rtl/spcm_line_cache_if.sv
// Bus-side port bundle for spcm_line_cache.
// Read handshake: the master raises bus_cs with bus_addr and holds both
// stable until the one-cycle bus_ack pulse; bus_dout is meaningful only
// while bus_ack=1 (and is driven to zero otherwise). flush is a one-cycle
// pulse from the master that invalidates the cached line.
interface spcm_line_cache_if #(
  parameter int ADDR_BITS = 24
);
  logic                 bus_cs;
  logic [ADDR_BITS-1:0] bus_addr;
  logic [31:0]          bus_dout;
  logic                 bus_ack;
  logic                 flush;

  modport master (
    output bus_cs, bus_addr, flush,
    input  bus_dout, bus_ack
  );

  modport slave (
    input  bus_cs, bus_addr, flush,
    output bus_dout, bus_ack
  );
endinterface

// File: rtl/spcm_line_cache.sv
// Single-line read cache in front of a serial PCM controller (spcm_core).
// A miss refills the whole line with one burst starting at word 0 and then
// answers the request. Optional hit/miss counters are built when the macro
// SPCM_CACHE_STAT_EN is defined; the default build has no counter ports.
// dbg_state exposes the FSM state (0 IDLE, 1 WAIT, 2 FILL, 3 RESP).
module spcm_line_cache #(
  parameter int ADDR_BITS  = 24,
  parameter int LINE_WORDS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  spcm_line_cache_if.slave     bus,
  output logic                 core_cs,
  output logic [ADDR_BITS-1:0] core_addr,
  output logic                 core_burst,
  input  logic [31:0]          core_dout,
  input  logic                 core_busy,
  input  logic                 core_ack,
`ifdef SPCM_CACHE_STAT_EN
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt,
`endif
  output logic [1:0]           dbg_state
);

  localparam int WIDX = $clog2(LINE_WORDS);
  localparam int OFF  = WIDX + 2;
  localparam int TAGW = ADDR_BITS - OFF;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]           state_q, state_d;
  logic                 valid_q, valid_d;
  logic [TAGW-1:0]      tag_q, tag_d;
  logic [WIDX-1:0]      word_q, word_d;
  logic [WIDX-1:0]      fill_cnt_q, fill_cnt_d;
  logic                 flush_pend_q, flush_pend_d;
  logic                 armed_q, armed_d;
  logic                 bus_ack_q, bus_ack_d;
  logic [31:0]          bus_dout_q, bus_dout_d;
  logic                 core_cs_q, core_cs_d;
  logic                 core_burst_q, core_burst_d;
  logic [ADDR_BITS-1:0] core_addr_q, core_addr_d;
  logic [31:0]          mem_q [LINE_WORDS];
`ifdef SPCM_CACHE_STAT_EN
  logic [31:0]          hit_cnt_q, hit_cnt_d;
  logic [31:0]          miss_cnt_q, miss_cnt_d;
`endif

  logic [TAGW-1:0] lk_tag;
  logic [WIDX-1:0] lk_word;
  logic            req, hit, last_ack, burst_end;
  logic            addr_lsb_unused;

  assign lk_tag          = bus.bus_addr[ADDR_BITS-1:OFF];
  assign lk_word         = bus.bus_addr[OFF-1:2];
  assign addr_lsb_unused = ^bus.bus_addr[1:0];
  // A request is only new once bus_cs has been seen low since the last ack.
  assign req       = bus.bus_cs & armed_q;
  // A flush in the same cycle as the lookup forces the miss path.
  assign hit       = req & valid_q & (lk_tag == tag_q) & ~bus.flush;
  assign last_ack  = core_ack & (fill_cnt_q == WIDX'(LINE_WORDS - 1));
  assign burst_end = core_ack & (fill_cnt_q == WIDX'(LINE_WORDS - 2));

  // Next-state logic for the lookup / refill / respond sequence.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    word_d       = word_q;
    fill_cnt_d   = fill_cnt_q;
    flush_pend_d = flush_pend_q;
    armed_d      = armed_q | ~bus.bus_cs;
    bus_ack_d    = 1'b0;
    bus_dout_d   = 32'h0;
    core_cs_d    = 1'b0;
    core_burst_d = core_burst_q;
    core_addr_d  = core_addr_q;
`ifdef SPCM_CACHE_STAT_EN
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.flush) valid_d = 1'b0;
        if (hit) begin
          bus_ack_d  = 1'b1;
          bus_dout_d = mem_q[lk_word];
          armed_d    = 1'b0;
        end else if (req) begin
          valid_d      = 1'b0;
          tag_d        = lk_tag;
          word_d       = lk_word;
          fill_cnt_d   = '0;
          flush_pend_d = 1'b0;
          state_d      = S_WAIT;
          if (!core_busy) begin
            core_cs_d    = 1'b1;
            core_burst_d = 1'b1;
            core_addr_d  = {lk_tag, {OFF{1'b0}}};
            state_d      = S_FILL;
          end
        end
      end
      S_WAIT: begin
        if (bus.flush) flush_pend_d = 1'b1;
        if (!core_busy) begin
          core_cs_d    = 1'b1;
          core_burst_d = 1'b1;
          core_addr_d  = {tag_q, {OFF{1'b0}}};
          state_d      = S_FILL;
        end
      end
      S_FILL: begin
        if (bus.flush) flush_pend_d = 1'b1;
        if (core_ack) fill_cnt_d = fill_cnt_q + WIDX'(1);
        if (burst_end) core_burst_d = 1'b0;
        if (last_ack) begin
          // The requested word may be the one arriving right now.
          valid_d    = ~(flush_pend_q | bus.flush);
          bus_ack_d  = 1'b1;
          bus_dout_d = (word_q == fill_cnt_q) ? core_dout : mem_q[word_q];
          armed_d    = 1'b0;
          state_d    = S_RESP;
        end
      end
      default: begin
        if (bus.flush) valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
`ifdef SPCM_CACHE_STAT_EN
    if (bus_ack_d && state_q == S_IDLE && hit_cnt_q != 32'hFFFF_FFFF)
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (core_cs_d && miss_cnt_q != 32'hFFFF_FFFF)
      miss_cnt_d = miss_cnt_q + 32'd1;
`endif
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      valid_q      <= 1'b0;
      tag_q        <= '0;
      word_q       <= '0;
      fill_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      armed_q      <= 1'b1;
      bus_ack_q    <= 1'b0;
      bus_dout_q   <= 32'h0;
      core_cs_q    <= 1'b0;
      core_burst_q <= 1'b0;
      core_addr_q  <= '0;
`ifdef SPCM_CACHE_STAT_EN
      hit_cnt_q    <= 32'h0;
      miss_cnt_q   <= 32'h0;
`endif
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      word_q       <= word_d;
      fill_cnt_q   <= fill_cnt_d;
      flush_pend_q <= flush_pend_d;
      armed_q      <= armed_d;
      bus_ack_q    <= bus_ack_d;
      bus_dout_q   <= bus_dout_d;
      core_cs_q    <= core_cs_d;
      core_burst_q <= core_burst_d;
      core_addr_q  <= core_addr_d;
`ifdef SPCM_CACHE_STAT_EN
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
`endif
    end
  end

  // Line data: written in fill order, never cleared.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_FILL && core_ack) mem_q[fill_cnt_q] <= core_dout;
  end

  assign bus.bus_ack  = bus_ack_q;
  assign bus.bus_dout = bus_dout_q;
  assign core_cs      = core_cs_q;
  assign core_burst   = core_burst_q;
  assign core_addr    = core_addr_q;
  assign dbg_state    = state_q;
`ifdef SPCM_CACHE_STAT_EN
  assign hit_cnt      = hit_cnt_q;
  assign miss_cnt     = miss_cnt_q;
`endif

endmodule

// File: tb/tb_spcm_line_cache.sv
// Directed bench for spcm_line_cache (ADDR_BITS=24, LINE_WORDS=8).
// Define SPCM_CACHE_STAT_EN on both DUT and bench to include the counter phase.
module tb_spcm_line_cache;
  logic        clk;
  logic        rst;
  logic        core_cs;
  logic [23:0] core_addr;
  logic        core_burst;
  logic [31:0] core_dout;
  logic        core_busy;
  logic        core_ack;
  logic [1:0]  dbg_state;
`ifdef SPCM_CACHE_STAT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  spcm_line_cache_if #(.ADDR_BITS(24)) bus_if ();

  spcm_line_cache #(.ADDR_BITS(24), .LINE_WORDS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .core_cs    (core_cs),
    .core_addr  (core_addr),
    .core_burst (core_burst),
    .core_dout  (core_dout),
    .core_busy  (core_busy),
    .core_ack   (core_ack),
`ifdef SPCM_CACHE_STAT_EN
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
`endif
    .dbg_state  (dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.bus_cs = 1'b0;
    bus_if.flush  = 1'b0;
    core_ack  = 1'b0;
    core_dout = 32'h0;
    core_busy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Wait (bounded) for the core start pulse and check the line base.
  task automatic wait_core_cs(input logic [31:0] exp_addr);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (core_cs === 1'b1) found = 1'b1;
    end
    check("core_cs_seen", {31'h0, found}, 32'h1);
    check("core_addr", {8'h0, core_addr}, exp_addr);
    check("core_burst_start", {31'h0, core_burst}, 32'h1);
  endtask

  // Deliver 8 words base..base+7, one idle cycle between acks.
  // flush_at >= 0 pulses flush in the gap after that ack.
  task automatic fill(input logic [31:0] base, input int flush_at);
    for (int i = 0; i < 8; i++) begin
      core_ack  = 1'b1;
      core_dout = base + 32'(i);
      tick();
      core_ack  = 1'b0;
      core_dout = 32'h0;
      if (i == 5) check("burst_after_ack6", {31'h0, core_burst}, 32'h1);
      if (i == 6) check("burst_after_ack7", {31'h0, core_burst}, 32'h0);
      if (i < 7) begin
        check("no_early_ack", {31'h0, bus_if.bus_ack}, 32'h0);
        if (i == flush_at) bus_if.flush = 1'b1;
        tick();
        bus_if.flush = 1'b0;
      end
    end
  endtask

  // Keep bus_cs high one more cycle (must not be re-served), then release.
  task automatic finish_read();
    tick();
    check("edge_qual_no_ack", {31'h0, bus_if.bus_ack}, 32'h0);
    check("edge_qual_no_core_cs", {31'h0, core_cs}, 32'h0);
    bus_if.bus_cs = 1'b0;
    tick();
    check("idle_ack", {31'h0, bus_if.bus_ack}, 32'h0);
    check("idle_dout", bus_if.bus_dout, 32'h0);
  endtask

  task automatic hit_read(input logic [23:0] addr, input logic [31:0] exp);
    bus_if.bus_cs   = 1'b1;
    bus_if.bus_addr = addr;
    tick();
    check("hit_ack", {31'h0, bus_if.bus_ack}, 32'h1);
    check("hit_dout", bus_if.bus_dout, exp);
    check("hit_no_core_cs", {31'h0, core_cs}, 32'h0);
    finish_read();
  endtask

  task automatic miss_read(input logic [23:0] addr, input logic [31:0] base,
                           input logic [31:0] exp);
    bus_if.bus_cs   = 1'b1;
    bus_if.bus_addr = addr;
    wait_core_cs({8'h0, addr & 24'hFFFFE0});
    fill(base, -1);
    check("miss_ack", {31'h0, bus_if.bus_ack}, 32'h1);
    check("miss_dout", bus_if.bus_dout, exp);
    finish_read();
  endtask

  initial begin
    bus_if.bus_addr = 24'h0;
    do_reset();
    check("rst_bus_ack", {31'h0, bus_if.bus_ack}, 32'h0);
    check("rst_bus_dout", bus_if.bus_dout, 32'h0);
    check("rst_core_cs", {31'h0, core_cs}, 32'h0);
    check("rst_core_burst", {31'h0, core_burst}, 32'h0);
    check("rst_core_addr", {8'h0, core_addr}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);

    // First read misses: fill 0xA0..0xA7, word 1 returned.
    miss_read(24'h000104, 32'hA0, 32'hA1);
    // Same line, last word: hit with latency 1.
    hit_read(24'h00011C, 32'hA7);
    hit_read(24'h000100, 32'hA0);

    // Next line while the core is busy: no start until busy drops.
    core_busy       = 1'b1;
    bus_if.bus_cs   = 1'b1;
    bus_if.bus_addr = 24'h000120;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("busy_no_core_cs", {31'h0, core_cs}, 32'h0);
    end
    check("busy_state_wait", {30'h0, dbg_state}, 32'h1);
    core_busy = 1'b0;
    tick();
    check("wait_core_cs", {31'h0, core_cs}, 32'h1);
    check("wait_core_addr", {8'h0, core_addr}, 32'h000120);
    fill(32'hB0, -1);
    check("wait_fill_ack", {31'h0, bus_if.bus_ack}, 32'h1);
    check("wait_fill_dout", bus_if.bus_dout, 32'hB0);
    finish_read();
    // Old line was evicted.
    miss_read(24'h000100, 32'hC0, 32'hC0);

    // Flush during fill: answered, but the line ends invalid.
    bus_if.bus_cs   = 1'b1;
    bus_if.bus_addr = 24'h000144;
    wait_core_cs(32'h000140);
    fill(32'hD0, 2);
    check("flush_fill_ack", {31'h0, bus_if.bus_ack}, 32'h1);
    check("flush_fill_dout", bus_if.bus_dout, 32'hD1);
    finish_read();
    bus_if.bus_cs = 1'b1;
    tick();
    check("reread_core_cs", {31'h0, core_cs}, 32'h1);
    check("reread_no_ack", {31'h0, bus_if.bus_ack}, 32'h0);
    fill(32'hE0, -1);
    check("reread_dout", bus_if.bus_dout, 32'hE1);
    finish_read();
    hit_read(24'h00015C, 32'hE7);

    // Flush coincident with a would-be hit: treated as a miss.
    bus_if.bus_cs   = 1'b1;
    bus_if.bus_addr = 24'h000148;
    bus_if.flush    = 1'b1;
    tick();
    bus_if.flush = 1'b0;
    check("flush_hit_core_cs", {31'h0, core_cs}, 32'h1);
    check("flush_hit_no_ack", {31'h0, bus_if.bus_ack}, 32'h0);
    fill(32'hF0, -1);
    check("flush_hit_dout", bus_if.bus_dout, 32'hF2);
    finish_read();

    // Flush while idle: next read of the same line misses.
    bus_if.flush = 1'b1;
    tick();
    bus_if.flush = 1'b0;
    miss_read(24'h000148, 32'h50, 32'h52);

    // Reset in the middle of a fill.
    bus_if.bus_cs   = 1'b1;
    bus_if.bus_addr = 24'h000200;
    wait_core_cs(32'h000200);
    for (int i = 0; i < 3; i++) begin
      core_ack  = 1'b1;
      core_dout = 32'h60 + 32'(i);
      tick();
      core_ack = 1'b0;
      tick();
    end
    rst = 1'b1;
    bus_if.bus_cs = 1'b0;
    tick();
    rst = 1'b0;
    check("midrst_ack", {31'h0, bus_if.bus_ack}, 32'h0);
    check("midrst_dout", bus_if.bus_dout, 32'h0);
    check("midrst_core_cs", {31'h0, core_cs}, 32'h0);
    check("midrst_burst", {31'h0, core_burst}, 32'h0);
    check("midrst_addr", {8'h0, core_addr}, 32'h0);
    core_ack  = 1'b1;
    core_dout = 32'hDEAD;
    tick();
    core_ack  = 1'b0;
    core_dout = 32'h0;
    check("stray_ack_no_bus_ack", {31'h0, bus_if.bus_ack}, 32'h0);
    check("stray_ack_state", {30'h0, dbg_state}, 32'h0);
    miss_read(24'h000208, 32'h30, 32'h32);
    hit_read(24'h000200, 32'h30);

`ifdef SPCM_CACHE_STAT_EN
    do_reset();
    check("stat_rst_hit", hit_cnt, 32'h0);
    check("stat_rst_miss", miss_cnt, 32'h0);
    miss_read(24'h000300, 32'h70, 32'h70);
    hit_read(24'h000304, 32'h71);
    hit_read(24'h000308, 32'h72);
    bus_if.flush = 1'b1;
    tick();
    bus_if.flush = 1'b0;
    miss_read(24'h000300, 32'h80, 32'h80);
    check("stat_hit_cnt", hit_cnt, 32'd2);
    check("stat_miss_cnt", miss_cnt, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
